// File: rtl/io_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_pkg
//  Description : Shared constants and FSM state encodings for the UART bridge
//                between the core's byte IO port and the board UART pins.
//  Contents    : UART_DATA_BITS, rx_state_e, tx_state_e
//  Revision    : 1.0 - initial release
// ============================================================================
package io_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/io_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : io_rx_fifo
//  Description : Synchronous FIFO buffering received UART bytes until the core
//                issues an IN. Pointers carry one extra wrap bit so full and
//                empty are distinguished without a counter.
//  Ports       : clk, rstn        clock, synchronous active-low reset
//                i_push/i_push_data write request and byte
//                i_pop            remove head entry
//                o_full/o_empty   occupancy status
//                o_head           entry at the read pointer (raw, ungated)
//  Revision    : 1.0 - initial release
// ============================================================================
module io_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int            c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0] c_ptr_one = (c_aw + 1)'(1);

    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    // Storage needs no reset: the head is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/io_uart_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : io_uart_bridge
//  Description : Bridges the core's io_in/io_out ready-valid byte handshakes to
//                an 8N1 UART. Received bytes are queued in io_rx_fifo so bytes
//                arriving with no IN pending survive; transmit bytes pass
//                through a one-entry hold register into the TX shifter.
//  Ports       : clk, rstn                 clock, synchronous active-low reset
//                uart_rxd / uart_txd       serial line in / out (idle high)
//                io_in_data/vld/rdy        byte to the core (FIFO head)
//                io_out_data/vld/rdy       byte from the core
//                rx_overrun, rx_frame_err  sticky receive error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module io_uart_bridge
    import io_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int RX_DEPTH    = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      uart_rxd,
    output logic                      uart_txd,
    output logic [UART_DATA_BITS-1:0] io_in_data,
    output logic                      io_in_vld,
    input  logic                      io_in_rdy,
    input  logic [UART_DATA_BITS-1:0] io_out_data,
    input  logic                      io_out_vld,
    output logic                      io_out_rdy,
    output logic                      rx_overrun,
    output logic                      rx_frame_err
);

    localparam int                  c_cnt_w     = $clog2(CLK_PER_BIT);
    localparam int                  c_bidx_w    = $clog2(UART_DATA_BITS);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLK_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLK_PER_BIT / 2 - 1);
    localparam logic [c_bidx_w-1:0] c_bidx_one  = c_bidx_w'(1);
    localparam logic [c_bidx_w-1:0] c_bidx_last = c_bidx_w'(UART_DATA_BITS - 1);

    // ------------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------------
    logic [1:0]                r_rxd_sync;
    logic                      w_rxd;
    rx_state_e                 r_rx_state, w_rx_state_nxt;
    logic [c_cnt_w-1:0]        r_rx_cnt, w_rx_cnt_nxt;
    logic [c_bidx_w-1:0]       r_rx_bit, w_rx_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                      w_rx_push;
    logic                      w_rx_bad_stop;
    logic                      r_rx_overrun;
    logic                      r_rx_frame_err;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [UART_DATA_BITS-1:0] w_fifo_head;
    logic                      w_in_pop;

    // Synchronizer resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rstn) r_rxd_sync <= 2'b11;
        else       r_rxd_sync <= {r_rxd_sync[0], uart_rxd};
    end
    assign w_rxd = r_rxd_sync[1];

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + c_cnt_one;
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_push      = 1'b0;
        w_rx_bad_stop  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nxt = '0;
                w_rx_bit_nxt = '0;
                if (!w_rxd) w_rx_state_nxt = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check; a line back high means it was a glitch.
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = w_rxd ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {w_rxd, r_rx_shift[UART_DATA_BITS-1:1]};
                    w_rx_bit_nxt   = r_rx_bit + c_bidx_one;
                    if (r_rx_bit == c_bidx_last) w_rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_state_nxt = RX_IDLE;
                    w_rx_push      = w_rxd;
                    w_rx_bad_stop  = !w_rxd;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rx_state     <= RX_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_overrun   <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            if (w_rx_push && w_fifo_full && !w_in_pop) r_rx_overrun <= 1'b1;
            if (w_rx_bad_stop)                         r_rx_frame_err <= 1'b1;
        end
    end

    assign w_in_pop = !w_fifo_empty && io_in_rdy;

    io_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_rx_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_push      (w_rx_push),
        .i_push_data (r_rx_shift),
        .i_pop       (w_in_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    assign io_in_vld    = !w_fifo_empty;
    assign io_in_data   = w_fifo_empty ? '0 : w_fifo_head;
    assign rx_overrun   = r_rx_overrun;
    assign rx_frame_err = r_rx_frame_err;

    // ------------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------------
    tx_state_e                 r_tx_state, w_tx_state_nxt;
    logic [c_cnt_w-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic [c_bidx_w-1:0]       r_tx_bit, w_tx_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                      r_txd, w_txd_nxt;
    logic                      w_tx_load;
    logic                      w_tx_bit_end;
    logic                      r_hold_vld;
    logic [UART_DATA_BITS-1:0] r_hold_data;
    logic                      r_out_rdy;
    logic                      w_out_xfer;

    assign w_out_xfer   = io_out_vld && r_out_rdy;
    assign w_tx_bit_end = (r_tx_cnt == c_bit_last);

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + c_cnt_one;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_txd_nxt      = r_txd;
        w_tx_load      = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_txd_nxt    = 1'b1;
                w_tx_load    = r_hold_vld;
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                    w_txd_nxt      = r_tx_shift[0];
                    w_tx_shift_nxt = r_tx_shift >> 1;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == c_bidx_last) begin
                        w_tx_state_nxt = TX_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + c_bidx_one;
                        w_txd_nxt      = r_tx_shift[0];
                        w_tx_shift_nxt = r_tx_shift >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_nxt = '0;
                    // Reloading straight from STOP keeps back-to-back frames gapless.
                    if (r_hold_vld) w_tx_load      = 1'b1;
                    else            w_tx_state_nxt = TX_IDLE;
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
        if (w_tx_load) begin
            w_tx_state_nxt = TX_START;
            w_tx_cnt_nxt   = '0;
            w_tx_shift_nxt = r_hold_data;
            w_txd_nxt      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cnt    <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_txd       <= 1'b1;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_out_rdy   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
            // A new byte wins over the shifter draining the old one on the same edge.
            if (w_out_xfer) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= io_out_data;
            end else if (w_tx_load) begin
                r_hold_vld  <= 1'b0;
            end
            // Ready trails the hold register by one cycle; the core offers a
            // byte for a single overlap cycle, so the lag is never exploited.
            r_out_rdy <= !r_hold_vld;
        end
    end

    assign uart_txd   = r_txd;
    assign io_out_rdy = r_out_rdy;

endmodule
`default_nettype wire

// File: tb/tb_io_uart_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_uart_bridge
//  Description : Randomized self-checking bench for io_uart_bridge with
//                CLK_PER_BIT = 16 and RX_DEPTH = 4. A queue models the RX FIFO
//                and expected TX frames are built as {stop, data, start} words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_uart_bridge;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rstn;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] io_in_data;
    logic       io_in_vld;
    logic       io_in_rdy;
    logic [7:0] io_out_data;
    logic       io_out_vld;
    logic       io_out_rdy;
    logic       rx_overrun;
    logic       rx_frame_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    logic       m_ovr;
    logic       m_ferr;

    io_uart_bridge #(
        .CLK_PER_BIT (CPB),
        .RX_DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_rxd     (uart_rxd),
        .uart_txd     (uart_txd),
        .io_in_data   (io_in_data),
        .io_in_vld    (io_in_vld),
        .io_in_rdy    (io_in_rdy),
        .io_out_data  (io_out_data),
        .io_out_vld   (io_out_vld),
        .io_out_rdy   (io_out_rdy),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One IN handshake; the popped byte must be the model's oldest byte.
    task automatic pop_one(input string tag);
        check_eq({tag, "_vld"}, 32'(io_in_vld), 32'd1);
        check_eq({tag, "_data"}, 32'(io_in_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
        io_in_rdy = 1'b1;
        tick();
        io_in_rdy = 1'b0;
    endtask

    // Drives one RX frame. pop_at >= 0 raises io_in_rdy for the edge that many
    // cycles after the falling start edge. rise reports when io_in_vld rose.
    task automatic send_rx(input logic [7:0] b, input bit stop, input int pop_at,
                           output int rise);
        logic [9:0] fr;
        logic       prev;
        fr   = {stop, b, 1'b0};
        rise = -1;
        prev = io_in_vld;
        for (int t = 0; t < 10 * CPB; t++) begin
            uart_rxd = fr[t / CPB];
            if (t + 1 == pop_at) begin
                check_eq("mid_pop_data", 32'(io_in_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                io_in_rdy = 1'b1;
            end else begin
                io_in_rdy = 1'b0;
            end
            tick();
            if (io_in_vld && !prev && rise < 0) rise = t + 1;
            prev = io_in_vld;
        end
        io_in_rdy = 1'b0;
        uart_rxd  = 1'b1;
        if (stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      m_ovr = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
        repeat (8) tick();
    endtask

    // Offers b0 (and b1 once ready returns, if two) and records uart_txd each
    // cycle after acceptance; frames must be exact and contiguous.
    task automatic tx_run(input logic [7:0] b0, input logic [7:0] b1, input bit two,
                          input string tag);
        logic        s [0:20*CPB];
        logic [19:0] exp_w;
        logic [19:0] got_w;
        int          n;
        int          unstable;
        int          rdy_low;
        bit          seen0;
        bit          offered;
        n     = two ? 20 * CPB : 10 * CPB;
        exp_w = two ? {1'b1, b1, 1'b0, 1'b1, b0, 1'b0} : {10'd0, 1'b1, b0, 1'b0};
        io_out_data = b0;
        io_out_vld  = 1'b1;
        tick();
        io_out_vld  = 1'b0;
        check_eq({tag, "_txd_at_A"}, 32'(uart_txd), 32'd1);
        rdy_low = io_out_rdy ? 0 : 1;
        seen0   = !io_out_rdy;
        offered = !two;
        for (int k = 1; k <= n; k++) begin
            tick();
            io_out_vld = 1'b0;
            s[k] = uart_txd;
            if (!io_out_rdy) begin
                rdy_low++;
                seen0 = 1'b1;
            end else if (seen0 && !offered) begin
                io_out_data = b1;
                io_out_vld  = 1'b1;
                offered     = 1'b1;
            end
        end
        got_w    = '0;
        unstable = 0;
        for (int j = 0; j < n / CPB; j++) begin
            got_w[j] = s[1 + CPB * j];
            for (int m = 1; m < CPB; m++)
                if (s[1 + CPB * j + m] !== s[1 + CPB * j]) unstable++;
        end
        check_eq({tag, "_frame_bits"}, 32'(got_w), 32'(exp_w));
        check_eq({tag, "_bit_glitches"}, 32'(unstable), 32'd0);
        if (!two) check_eq({tag, "_rdy_low_cycles"}, 32'(rdy_low), 32'd1);
        tick();
        check_eq({tag, "_idle_after"}, 32'(uart_txd), 32'd1);
        repeat (4) tick();
    endtask

    initial begin
        int         rise;
        int         viol;
        logic [7:0] b;

        rstn        = 1'b0;
        uart_rxd    = 1'b1;
        io_in_rdy   = 1'b0;
        io_out_data = 8'h00;
        io_out_vld  = 1'b0;
        m_ovr       = 1'b0;
        m_ferr      = 1'b0;
        repeat (3) tick();
        check_eq("rst_txd", 32'(uart_txd), 32'd1);
        check_eq("rst_in_vld", 32'(io_in_vld), 32'd0);
        check_eq("rst_in_data", 32'(io_in_data), 32'd0);
        check_eq("rst_out_rdy", 32'(io_out_rdy), 32'd1);
        check_eq("rst_overrun", 32'(rx_overrun), 32'd0);
        check_eq("rst_frame_err", 32'(rx_frame_err), 32'd0);
        rstn = 1'b1;
        repeat (4) tick();

        // RX: fixed 0xA5 then random bytes, each consumed by one IN.
        send_rx(8'hA5, 1'b1, -1, rise);
        check_eq("rx_a5_vld_rise", 32'(rise), 32'd155);
        pop_one("rx_a5");
        check_eq("rx_a5_empty_vld", 32'(io_in_vld), 32'd0);
        check_eq("rx_a5_empty_data", 32'(io_in_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1, -1, rise);
            check_eq("rx_rand_vld_rise", 32'(rise), 32'd155);
            pop_one("rx_rand");
        end

        // TX: single frames, then back-to-back pairs.
        tx_run(8'h3C, 8'h00, 1'b0, "tx_3c");
        for (int i = 0; i < 2; i++) tx_run(8'($urandom), 8'h00, 1'b0, "tx_rand");
        tx_run(8'h01, 8'h80, 1'b1, "tx_b2b");
        tx_run(8'($urandom), 8'($urandom), 1'b1, "tx_b2b_rand");

        // FIFO fill, simultaneous push/pop while full, then a real overrun.
        for (int i = 0; i < DEPTH; i++) send_rx(8'($urandom), 1'b1, -1, rise);
        check_eq("full_no_overrun", 32'(rx_overrun), 32'(m_ovr));
        send_rx(8'($urandom), 1'b1, 155, rise);
        check_eq("push_pop_full_overrun", 32'(rx_overrun), 32'd0);
        send_rx(8'($urandom), 1'b1, -1, rise);
        check_eq("overrun_set", 32'(rx_overrun), 32'(m_ovr));
        for (int i = 0; i < DEPTH; i++) pop_one("drain");
        check_eq("drain_empty", 32'(io_in_vld), 32'd0);

        // Bad stop bit: byte dropped, sticky frame error.
        send_rx(8'($urandom), 1'b0, -1, rise);
        repeat (20) tick();
        check_eq("ferr_no_push", 32'(io_in_vld), 32'd0);
        check_eq("ferr_set", 32'(rx_frame_err), 32'(m_ferr));

        // Short low glitch must not start a frame; a following frame is clean.
        uart_rxd = 1'b0;
        repeat (4) tick();
        uart_rxd = 1'b1;
        repeat (40) tick();
        check_eq("glitch_no_push", 32'(io_in_vld), 32'd0);
        b = 8'($urandom);
        send_rx(b, 1'b1, -1, rise);
        check_eq("post_glitch_rise", 32'(rise), 32'd155);
        check_eq("post_glitch_ferr", 32'(rx_frame_err), 32'(m_ferr));

        // Reset with data buffered, a TX frame and an RX frame in flight.
        io_out_data = 8'($urandom);
        io_out_vld  = 1'b1;
        tick();
        io_out_vld  = 1'b0;
        uart_rxd    = 1'b0;
        repeat (40) tick();
        check_eq("pre_rst_overrun", 32'(rx_overrun), 32'(m_ovr));
        check_eq("pre_rst_in_vld", 32'(io_in_vld), 32'd1);
        rstn     = 1'b0;
        uart_rxd = 1'b1;
        tick();
        check_eq("midrst_txd", 32'(uart_txd), 32'd1);
        check_eq("midrst_in_vld", 32'(io_in_vld), 32'd0);
        check_eq("midrst_out_rdy", 32'(io_out_rdy), 32'd1);
        check_eq("midrst_overrun", 32'(rx_overrun), 32'd0);
        check_eq("midrst_frame_err", 32'(rx_frame_err), 32'd0);
        rstn = 1'b1;
        exp_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        viol   = 0;
        for (int k = 0; k < 12 * CPB; k++) begin
            tick();
            if (uart_txd !== 1'b1 || io_in_vld !== 1'b0) viol++;
        end
        check_eq("post_rst_quiet", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
